// File: rtl/sdram_responder.sv
// sdram_responder
//   Cycle-accurate device-side model of a single-data-rate SDRAM
//   (MT48LC16M16 subset). Decodes controller commands, stores words in an
//   internal array, returns read data at the programmed CAS latency and
//   records the first protocol/timing violation it observes.
//
// Ports
//   clk, reset            device clock, asynchronous active-high reset
//   cke                   clock enable; low freezes command decode and read path
//   ncs/nras/ncas/nwe     command pins
//   ba, a                 bank address, multiplexed row/column address
//   dqml, dqmh            byte masks (1 = masked)
//   dq_in                 write data from the bus
//   dq_out, dq_oe         registered read data and its drive enable
//   mode_set, cas_lat     LOAD_MODE accepted, programmed CAS latency (2 or 3)
//   refresh_cnt           AUTO_REFRESH counter (wraps)
//   err, err_code         sticky violation flag and code of the first violation
module sdram_responder #(
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned COL_BITS = 9,
    parameter int unsigned TRCD     = 2,
    parameter int unsigned TRP      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cke,
    input  logic        ncs,
    input  logic        nras,
    input  logic        ncas,
    input  logic        nwe,
    input  logic [1:0]  ba,
    input  logic [12:0] a,
    input  logic        dqml,
    input  logic        dqmh,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        mode_set,
    output logic [1:0]  cas_lat,
    output logic [15:0] refresh_cnt,
    output logic        err,
    output logic [3:0]  err_code
);

    localparam int unsigned ADDR_BITS = 2 + ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam int unsigned TMAX      = (TRCD > TRP) ? TRCD : TRP;
    localparam int unsigned TW        = $clog2(TMAX + 2);
    // Timers hold "edges still to wait"; a command is legal once the timer is 0.
    localparam logic [TW-1:0] TRCD_INIT = TW'((TRCD > 0) ? TRCD - 1 : 0);
    localparam logic [TW-1:0] TRP_INIT  = TW'((TRP > 0) ? TRP - 1 : 0);

    typedef enum logic [3:0] {
        CMD_LOAD_MODE  = 4'b0000,
        CMD_REFRESH    = 4'b0001,
        CMD_PRECHARGE  = 4'b0010,
        CMD_ACTIVE     = 4'b0011,
        CMD_WRITE      = 4'b0100,
        CMD_READ       = 4'b0101,
        CMD_BURST_TERM = 4'b0110,
        CMD_NOP        = 4'b0111
    } cmd_t;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_t;

    cmd_t                 cmd;
    bank_state_t          bank_state [4];
    bank_state_t          bank_next  [4];
    logic [ROW_BITS-1:0]  row_q      [4];
    logic [TW-1:0]        trcd_q     [4];
    logic [TW-1:0]        trp_q      [4];
    logic [3:0]           prech_hit;

    logic [15:0]          mem [DEPTH];

    logic                 any_active;
    logic                 any_trp_busy;
    logic                 bank_active_sel;
    logic                 mode_ok;
    logic                 is_access;
    logic                 access_ok;
    logic                 rd_fire;
    logic [ADDR_BITS-1:0] addr;
    logic [15:0]          rd_word;
    logic [15:0]          rd_data;
    logic                 viol;
    logic [3:0]           viol_code;

    logic                 pipe_vld0, pipe_vld1;
    logic [15:0]          pipe_d0, pipe_d1;
    logic                 tap_vld;
    logic [15:0]          tap_data;

    logic                 unused_addr_bits;
    assign unused_addr_bits = ^{a[12:11], a[9]};

    // ------------------------------------------------------------------
    // Command decode and shared status
    // ------------------------------------------------------------------
    always_comb begin
        if (!cke || ncs) cmd = CMD_NOP;
        else             cmd = cmd_t'({1'b0, nras, ncas, nwe});
    end

    always_comb begin
        any_active   = 1'b0;
        any_trp_busy = 1'b0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (bank_state[b] == BANK_ACTIVE) any_active = 1'b1;
            if (trp_q[b] != '0)               any_trp_busy = 1'b1;
        end
    end

    assign bank_active_sel = (bank_state[ba] == BANK_ACTIVE);
    assign mode_ok   = ((a[6:4] == 3'd2) || (a[6:4] == 3'd3)) && (a[2:0] == 3'b000);
    assign is_access = (cmd == CMD_READ) || (cmd == CMD_WRITE);
    assign access_ok = is_access && bank_active_sel;
    assign rd_fire   = (cmd == CMD_READ) && bank_active_sel;
    assign addr      = {ba, row_q[ba], a[COL_BITS-1:0]};

    // Violation classification; priority within a command picks one code.
    always_comb begin
        viol      = 1'b0;
        viol_code = '0;
        unique case (cmd)
            CMD_ACTIVE: begin
                if (!mode_set) begin
                    viol = 1'b1; viol_code = 4'd1;
                end else if (bank_active_sel) begin
                    viol = 1'b1; viol_code = 4'd2;
                end else if (trp_q[ba] != '0) begin
                    viol = 1'b1; viol_code = 4'd7;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (!mode_set) begin
                    viol = 1'b1; viol_code = 4'd1;
                end else if (!bank_active_sel) begin
                    viol = 1'b1; viol_code = 4'd3;
                end else if (trcd_q[ba] != '0) begin
                    viol = 1'b1; viol_code = 4'd4;
                end
            end
            CMD_REFRESH: begin
                if (any_active) begin
                    viol = 1'b1; viol_code = 4'd5;
                end else if (any_trp_busy) begin
                    viol = 1'b1; viol_code = 4'd7;
                end
            end
            CMD_LOAD_MODE: begin
                if (any_active) begin
                    viol = 1'b1; viol_code = 4'd5;
                end else if (!mode_ok) begin
                    viol = 1'b1; viol_code = 4'd6;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-bank FSM
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned b = 0; b < 4; b++) begin
            // Explicit precharge of this bank, or auto-precharge of an access to it.
            prech_hit[b] = ((cmd == CMD_PRECHARGE) && (a[10] || (ba == 2'(b)))) ||
                           (access_ok && a[10] && (ba == 2'(b)));
            bank_next[b] = bank_state[b];
            unique case (bank_state[b])
                BANK_IDLE:
                    if ((cmd == CMD_ACTIVE) && (ba == 2'(b))) bank_next[b] = BANK_ACTIVE;
                BANK_ACTIVE:
                    if (prech_hit[b]) bank_next[b] = BANK_IDLE;
                default: bank_next[b] = BANK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned b = 0; b < 4; b++) begin
                bank_state[b] <= BANK_IDLE;
                row_q[b]      <= '0;
                trcd_q[b]     <= '0;
                trp_q[b]      <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                bank_state[b] <= bank_next[b];
                if ((cmd == CMD_ACTIVE) && (ba == 2'(b))) begin
                    row_q[b]  <= a[ROW_BITS-1:0];
                    trcd_q[b] <= TRCD_INIT;
                end else if (trcd_q[b] != '0) begin
                    trcd_q[b] <= trcd_q[b] - TW'(1);
                end
                if (prech_hit[b]) begin
                    trp_q[b] <= TRP_INIT;
                end else if (trp_q[b] != '0) begin
                    trp_q[b] <= trp_q[b] - TW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((cmd == CMD_WRITE) && bank_active_sel) begin
            if (!dqml) mem[addr][7:0]  <= dq_in[7:0];
            if (!dqmh) mem[addr][15:8] <= dq_in[15:8];
        end
    end

    // Mask is applied when the word is captured, so a later WRITE to the
    // same location cannot alter data already in flight.
    assign rd_word = mem[addr];
    assign rd_data = {dqmh ? 8'h00 : rd_word[15:8], dqml ? 8'h00 : rd_word[7:0]};

    // ------------------------------------------------------------------
    // Read pipeline: two capture stages plus the output register. CL=2
    // taps stage 0, CL=3 taps stage 1, so data appears at edge E+CL-1.
    // ------------------------------------------------------------------
    always_comb begin
        tap_vld  = (cas_lat == 2'd3) ? pipe_vld1 : pipe_vld0;
        tap_data = (cas_lat == 2'd3) ? pipe_d1   : pipe_d0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld0 <= 1'b0;
            pipe_vld1 <= 1'b0;
            pipe_d0   <= '0;
            pipe_d1   <= '0;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else if (cke) begin
            if (cmd == CMD_BURST_TERM) begin
                pipe_vld0 <= 1'b0;
                pipe_vld1 <= 1'b0;
                dq_oe     <= 1'b0;
                dq_out    <= '0;
            end else begin
                pipe_vld0 <= rd_fire;
                pipe_d0   <= rd_data;
                pipe_vld1 <= pipe_vld0;
                pipe_d1   <= pipe_d0;
                dq_oe     <= tap_vld;
                dq_out    <= tap_vld ? tap_data : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode register, refresh counter, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_set    <= 1'b0;
            cas_lat     <= 2'd2;
            refresh_cnt <= '0;
            err         <= 1'b0;
            err_code    <= '0;
        end else begin
            if ((cmd == CMD_LOAD_MODE) && mode_ok) begin
                mode_set <= 1'b1;
                cas_lat  <= a[5:4];
            end
            if (cmd == CMD_REFRESH) refresh_cnt <= refresh_cnt + 16'd1;
            if (viol && !err) begin
                err      <= 1'b1;
                err_code <= viol_code;
            end
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder
//   Directed bench for sdram_responder: init sequence, CL=2/CL=3 reads,
//   byte masks, violation codes and reset during an outstanding read.
module tb_sdram_responder;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_LMR  = 4'b0000;

    logic        clk;
    logic        reset;
    logic        cke;
    logic        ncs, nras, ncas, nwe;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        dqml, dqmh;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        mode_set;
    logic [1:0]  cas_lat;
    logic [15:0] refresh_cnt;
    logic        err;
    logic [3:0]  err_code;

    int unsigned checks = 0;
    int unsigned errors = 0;

    sdram_responder #(
        .ROW_BITS (4),
        .COL_BITS (9),
        .TRCD     (2),
        .TRP      (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .ncs         (ncs),
        .nras        (nras),
        .ncas        (ncas),
        .nwe         (nwe),
        .ba          (ba),
        .a           (a),
        .dqml        (dqml),
        .dqmh        (dqmh),
        .dq_in       (dq_in),
        .dq_out      (dq_out),
        .dq_oe       (dq_oe),
        .mode_set    (mode_set),
        .cas_lat     (cas_lat),
        .refresh_cnt (refresh_cnt),
        .err         (err),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a command for one edge, return 1ns after that edge with pins at NOP.
    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr,
                         input logic [15:0] d, input logic ml, input logic mh);
        {ncs, nras, ncas, nwe} = c;
        ba    = b;
        a     = addr;
        dq_in = d;
        dqml  = ml;
        dqmh  = mh;
        @(posedge clk);
        #1;
        {ncs, nras, ncas, nwe} = C_NOP;
        dqml = 1'b0;
        dqmh = 1'b0;
    endtask

    task automatic nop(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ACTIVE, wait tRCD, WRITE with auto-precharge.
    task automatic wr_cycle(input logic [1:0] b, input logic [3:0] row, input logic [8:0] col,
                            input logic [15:0] d, input logic ml, input logic mh);
        nop(1);
        issue(C_ACT, b, {9'd0, row}, '0, 1'b0, 1'b0);
        nop(1);
        issue(C_WR, b, {3'b001, 1'b0, col}, d, ml, mh);
    endtask

    // ACTIVE, wait tRCD, READ with auto-precharge at edge E; dq_oe must be
    // high only after edge E+cl-1 and low again after edge E+cl.
    task automatic rd_cycle(input string tag, input logic [1:0] b, input logic [3:0] row,
                            input logic [8:0] col, input logic ml, input logic mh,
                            input int unsigned cl, input logic [15:0] exp);
        nop(1);
        issue(C_ACT, b, {9'd0, row}, '0, 1'b0, 1'b0);
        nop(1);
        issue(C_RD, b, {3'b001, 1'b0, col}, '0, ml, mh);
        check($sformatf("%s_oe_e0", tag), 32'(dq_oe), 32'd0);
        for (int unsigned k = 1; k <= 3; k++) begin
            nop(1);
            check($sformatf("%s_oe_e%0d", tag, k), 32'(dq_oe), 32'(k == cl - 1));
            if (k == cl - 1) check($sformatf("%s_data", tag), 32'(dq_out), 32'(exp));
        end
    endtask

    initial begin
        reset = 1'b1;
        cke   = 1'b1;
        {ncs, nras, ncas, nwe} = 4'b1111;
        ba    = '0;
        a     = '0;
        dqml  = 1'b0;
        dqmh  = 1'b0;
        dq_in = '0;
        nop(3);
        check("rst_dq_oe",    32'(dq_oe),       32'd0);
        check("rst_dq_out",   32'(dq_out),      32'd0);
        check("rst_mode_set", 32'(mode_set),    32'd0);
        check("rst_cas_lat",  32'(cas_lat),     32'd2);
        check("rst_refresh",  32'(refresh_cnt), 32'd0);
        check("rst_err",      32'(err),         32'd0);
        check("rst_err_code", 32'(err_code),    32'd0);
        reset = 1'b0;
        {ncs, nras, ncas, nwe} = C_NOP;
        nop(1);

        // 1: init sequence
        issue(C_PRE, 2'd0, 13'h400, '0, 1'b0, 1'b0);
        nop(2);
        for (int unsigned i = 0; i < 8; i++) issue(C_REF, 2'd0, 13'h000, '0, 1'b0, 1'b0);
        issue(C_LMR, 2'd0, 13'h220, '0, 1'b0, 1'b0);
        check("init_mode_set", 32'(mode_set),    32'd1);
        check("init_cas_lat",  32'(cas_lat),     32'd2);
        check("init_refresh",  32'(refresh_cnt), 32'd8);
        check("init_err",      32'(err),         32'd0);

        // 2: write then read at CL=2
        wr_cycle(2'd1, 4'd5, 9'h01A, 16'hA55A, 1'b0, 1'b0);
        rd_cycle("cl2", 2'd1, 4'd5, 9'h01A, 1'b0, 1'b0, 2, 16'hA55A);

        // 3: high byte masked on write; then low byte masked on read
        wr_cycle(2'd1, 4'd5, 9'h01A, 16'h1234, 1'b0, 1'b1);
        rd_cycle("mask_wr", 2'd1, 4'd5, 9'h01A, 1'b0, 1'b0, 2, 16'hA534);
        rd_cycle("mask_rd", 2'd1, 4'd5, 9'h01A, 1'b1, 1'b0, 2, 16'hA500);

        // 4: CL=3
        issue(C_LMR, 2'd0, 13'h230, '0, 1'b0, 1'b0);
        check("cl3_cas_lat", 32'(cas_lat), 32'd3);
        rd_cycle("cl3", 2'd1, 4'd5, 9'h01A, 1'b0, 1'b0, 3, 16'hA534);
        // All banks closed by auto-precharge: refresh is legal.
        issue(C_REF, 2'd0, 13'h000, '0, 1'b0, 1'b0);
        check("idle_refresh", 32'(refresh_cnt), 32'd9);
        check("idle_err",     32'(err),         32'd0);

        // 5: violations
        issue(C_RD, 2'd2, 13'h000, '0, 1'b0, 1'b0);
        check("v_err",      32'(err),      32'd1);
        check("v_err_code", 32'(err_code), 32'd3);
        for (int unsigned k = 1; k <= 4; k++) begin
            nop(1);
            check($sformatf("v_oe_e%0d", k), 32'(dq_oe), 32'd0);
        end
        issue(C_PRE, 2'd2, 13'h000, '0, 1'b0, 1'b0);
        issue(C_ACT, 2'd2, 13'h001, '0, 1'b0, 1'b0);
        check("v_trp_code", 32'(err_code), 32'd3);

        // 6: reset while two back-to-back reads are in flight
        issue(C_PRE, 2'd0, 13'h400, '0, 1'b0, 1'b0);
        nop(2);
        issue(C_LMR, 2'd0, 13'h220, '0, 1'b0, 1'b0);
        check("r_cas_lat", 32'(cas_lat), 32'd2);
        wr_cycle(2'd0, 4'd3, 9'h005, 16'hBEEF, 1'b0, 1'b0);
        nop(1);
        issue(C_ACT, 2'd0, 13'h003, '0, 1'b0, 1'b0);
        nop(1);
        issue(C_RD, 2'd0, 13'h005, '0, 1'b0, 1'b0);
        issue(C_RD, 2'd0, 13'h005, '0, 1'b0, 1'b0);
        check("r_pre_oe",   32'(dq_oe),  32'd1);
        check("r_pre_data", 32'(dq_out), 32'hBEEF);
        reset = 1'b1;
        #1;
        check("r_oe",       32'(dq_oe),    32'd0);
        check("r_mode_set", 32'(mode_set), 32'd0);
        check("r_err",      32'(err),      32'd0);
        check("r_err_code", 32'(err_code), 32'd0);
        nop(1);
        reset = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            nop(1);
            check($sformatf("r_post_oe%0d", k), 32'(dq_oe), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
